// File: rtl/pxie_tx_data.sv
// C2H readback packetizer: fetches a block of 64-bit words from system RAM and
// streams it as header + payload + tail under valid/ready flow control.
module pxie_tx_data #(
    parameter int          RD_LAT     = 2,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] HDR_ID     = 16'h2000
) (
    input  logic        I_PXIE_CLK,
    input  logic        I_Rst_n,
    input  logic        I_c2h_en,
    input  logic [15:0] I_c2h_addr,
    input  logic [15:0] I_c2h_len,
    output logic [31:0] O_rd_addr,
    output logic        O_rd_en,
    input  logic [63:0] I_rd_data,
    output logic [63:0] O_PXIE_DATA,
    output logic        O_PXIE_DATA_VLD,
    input  logic        I_PXIE_TX_RDY,
    output logic        O_busy,
    output logic        O_done,
    output logic        O_drop
);

    localparam int               AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW+1:0]    DEPTH_W = FIFO_DEPTH[AW+1:0];

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_HEAD = 5'b00010,
        ST_DATA = 5'b00100,
        ST_TAIL = 5'b01000,
        ST_DONE = 5'b10000
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_addr;
    logic [15:0] r_len;
    logic [31:0] r_csum;
    logic [16:0] r_rd_cnt;
    logic [16:0] r_tx_cnt;
    logic        r_drop;

    logic [RD_LAT-1:0] r_vld_sr;
    logic [RD_LAT-1:0] w_vld_sr_nxt;
    logic [AW:0]       r_inflight;
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [63:0]       r_fifo [FIFO_DEPTH];

    logic [AW:0]  w_occ;
    logic         w_empty;
    logic         w_rd_en;
    logic         w_vld;
    logic [63:0]  w_data;
    logic         w_xfer;
    logic         w_pop;
    logic         w_ret;

    assign w_occ   = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_occ == '0);
    assign w_ret   = r_vld_sr[RD_LAT-1];

    // Occupancy plus in-flight reads bounds the FIFO, so returning data always has a slot.
    assign w_rd_en = ((r_state == ST_HEAD) || (r_state == ST_DATA)) &&
                     (r_rd_cnt < {1'b0, r_len}) &&
                     (({1'b0, w_occ} + {1'b0, r_inflight}) < DEPTH_W);

    always_comb begin
        w_vld_sr_nxt[0] = w_rd_en;
        for (int i = 1; i < RD_LAT; i++) begin
            w_vld_sr_nxt[i] = r_vld_sr[i-1];
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        w_vld       = 1'b0;
        w_data      = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (I_c2h_en) w_state_nxt = ST_HEAD;
            end
            ST_HEAD: begin
                w_vld  = 1'b1;
                w_data = {16'heb9c, r_len, r_addr, HDR_ID};
                if (I_PXIE_TX_RDY) w_state_nxt = (r_len != 16'd0) ? ST_DATA : ST_TAIL;
            end
            ST_DATA: begin
                w_vld  = !w_empty;
                w_data = w_empty ? '0 : r_fifo[r_rd_ptr[AW-1:0]];
                if (w_vld && I_PXIE_TX_RDY && ((r_tx_cnt + 17'd1) == {1'b0, r_len}))
                    w_state_nxt = ST_TAIL;
            end
            ST_TAIL: begin
                w_vld  = 1'b1;
                w_data = {16'heb9d, r_len, r_csum};
                if (I_PXIE_TX_RDY) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_xfer = w_vld && I_PXIE_TX_RDY;
    assign w_pop  = w_xfer && (r_state == ST_DATA);

    // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_len      <= '0;
            r_csum     <= '0;
            r_rd_cnt   <= '0;
            r_tx_cnt   <= '0;
            r_drop     <= 1'b0;
            r_vld_sr   <= '0;
            r_inflight <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_drop     <= I_c2h_en && (r_state != ST_IDLE);
            r_vld_sr   <= w_vld_sr_nxt;
            r_inflight <= r_inflight + {{AW{1'b0}}, w_rd_en} - {{AW{1'b0}}, w_ret};
            if (w_ret) r_wr_ptr <= r_wr_ptr + 1'b1;
            if ((r_state == ST_IDLE) && I_c2h_en) begin
                r_addr   <= I_c2h_addr;
                r_len    <= I_c2h_len;
                r_csum   <= '0;
                r_rd_cnt <= '0;
                r_tx_cnt <= '0;
            end else begin
                if (w_rd_en) r_rd_cnt <= r_rd_cnt + 17'd1;
                if (w_pop) begin
                    r_tx_cnt <= r_tx_cnt + 17'd1;
                    r_csum   <= r_csum + w_data[63:32] + w_data[31:0];
                end
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: the FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge I_PXIE_CLK) begin
        if (w_ret) r_fifo[r_wr_ptr[AW-1:0]] <= I_rd_data;
    end

    assign O_rd_en         = w_rd_en;
    assign O_rd_addr       = w_rd_en ? ({16'h0, r_addr} + {14'h0, r_rd_cnt, 1'b0}) : '0;
    assign O_PXIE_DATA     = w_data;
    assign O_PXIE_DATA_VLD = w_vld;
    assign O_busy          = (r_state != ST_IDLE);
    assign O_done          = (r_state == ST_DONE);
    assign O_drop          = r_drop;

endmodule

// File: tb/tb_pxie_tx_data.sv
// Directed bench for pxie_tx_data: RAM responder, stream monitor and one task per scenario.
module tb_pxie_tx_data;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        c2h_en = 1'b0;
    logic [15:0] c2h_addr = '0;
    logic [15:0] c2h_len = '0;
    logic [31:0] rd_addr;
    logic        rd_en;
    logic [63:0] rd_data;
    logic [63:0] tx_data;
    logic        tx_vld;
    logic        tx_rdy = 1'b0;
    logic        busy;
    logic        done;
    logic        drop;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pxie_tx_data #(.RD_LAT(RD_LAT), .FIFO_DEPTH(8), .HDR_ID(16'h2000)) dut (
        .I_PXIE_CLK     (clk),
        .I_Rst_n        (rst_n),
        .I_c2h_en       (c2h_en),
        .I_c2h_addr     (c2h_addr),
        .I_c2h_len      (c2h_len),
        .O_rd_addr      (rd_addr),
        .O_rd_en        (rd_en),
        .I_rd_data      (rd_data),
        .O_PXIE_DATA    (tx_data),
        .O_PXIE_DATA_VLD(tx_vld),
        .I_PXIE_TX_RDY  (tx_rdy),
        .O_busy         (busy),
        .O_done         (done),
        .O_drop         (drop)
    );

    // RAM responder: data for a read appears RD_LAT cycles after its strobe.
    bit ram_hi_mode = 1'b0;

    function automatic logic [63:0] ram_word(input logic [31:0] a);
        ram_word = {ram_hi_mode ? (a ^ 32'h5A5A_C3C3) : 32'h0, a};
    endfunction

    logic        pipe_v [RD_LAT];
    logic [31:0] pipe_a [RD_LAT];

    always @(posedge clk) begin
        pipe_v[0] <= rd_en;
        pipe_a[0] <= rd_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
        end
    end

    assign rd_data = (pipe_v[RD_LAT-1] === 1'b1) ? ram_word(pipe_a[RD_LAT-1]) : 64'hDEAD_BEEF_DEAD_BEEF;

    // Expected stream word idx: 0 header, 1..l payload, l+1 tail.
    function automatic logic [63:0] exp_word(input logic [15:0] a, input logic [15:0] l, input int idx);
        logic [31:0] cs;
        logic [63:0] w;
        cs = '0;
        if (idx == 0) return {16'heb9c, l, a, 16'h2000};
        if (idx <= int'(l)) return ram_word({16'h0, a} + 32'(2 * (idx - 1)));
        for (int i = 0; i < int'(l); i++) begin
            w  = ram_word({16'h0, a} + 32'(2 * i));
            cs = cs + w[63:32] + w[31:0];
        end
        return {16'heb9d, l, cs};
    endfunction

    // Monitor, sampled on the falling edge.
    logic [63:0] got [$];
    logic [31:0] rd_q [$];
    int          done_cnt = 0;
    int          drop_cnt = 0;
    int          stab_err = 0;
    int          max_sum  = 0;
    int          pk_issued = 0;
    int          pk_xfer   = 0;
    int          cur_len   = 0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data = '0;

    always @(negedge clk) begin
        int popped;
        int sum;
        if (!rst_n) begin
            pk_issued  = 0;
            pk_xfer    = 0;
            prev_stall = 1'b0;
        end else begin
            popped = (pk_xfer == 0) ? 0 : (((pk_xfer - 1) > cur_len) ? cur_len : (pk_xfer - 1));
            sum    = pk_issued + (rd_en ? 1 : 0) - popped;
            if (sum > max_sum) max_sum = sum;
            if (prev_stall && (!tx_vld || (tx_data !== prev_data))) stab_err++;
            prev_stall = tx_vld && !tx_rdy;
            prev_data  = tx_data;
            if (rd_en) begin
                rd_q.push_back(rd_addr);
                pk_issued++;
            end
            if (tx_vld && tx_rdy) begin
                got.push_back(tx_data);
                pk_xfer++;
            end
            if (drop) drop_cnt++;
            if (done) begin
                done_cnt++;
                pk_issued = 0;
                pk_xfer   = 0;
            end
        end
    end

    task automatic clear_mon();
        got.delete();
        rd_q.delete();
        done_cnt = 0;
        drop_cnt = 0;
        stab_err = 0;
        max_sum  = 0;
    endtask

    // mode 0: RDY=1; mode 1: random 30% RDY plus one 20-cycle stall; mode 2: RDY=1 with two colliding requests.
    task automatic run_pkt(input logic [15:0] a, input logic [15:0] l, input int mode,
                           output bit to, output int first_vld);
        int  x = 0;
        int  cyc = 0;
        int  stall_left = 0;
        bit  stalled = 1'b0;
        bit  inject = 1'b0;
        to        = 1'b0;
        first_vld = -1;
        cur_len   = int'(l);
        @(posedge clk); #1;
        c2h_en = 1'b1; c2h_addr = a; c2h_len = l; tx_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_vld && first_vld < 0) first_vld = cyc;
            if (tx_vld && tx_rdy) begin
                x++;
                if (mode == 2 && (x == 3 || x == int'(l) + 2)) inject = 1'b1;
            end
            if (done) break;
            cyc++;
            if (cyc > 3000) begin
                to = 1'b1;
                break;
            end
            @(posedge clk); #1;
            c2h_en = inject;
            if (inject) begin
                c2h_addr = 16'h0BAD;
                c2h_len  = 16'h0033;
            end
            inject = 1'b0;
            if (mode == 1) begin
                if (stall_left > 0) begin
                    tx_rdy = 1'b0;
                    stall_left--;
                end else if (!stalled && x >= 12) begin
                    stalled    = 1'b1;
                    stall_left = 19;
                    tx_rdy     = 1'b0;
                end else begin
                    tx_rdy = ($urandom_range(0, 99) < 30);
                end
            end else begin
                tx_rdy = 1'b1;
            end
        end
        @(posedge clk); #1;
        c2h_en = 1'b0;
        tx_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({rd_en, tx_vld, busy, done, drop} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=00000", {rd_en, tx_vld, busy, done, drop});
        end
        total++;
        if (tx_data !== 64'h0 || rd_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_data got data=%h addr=%h want 0/0", tx_data, rd_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_nominal();
        bit to;
        int fv;
        logic [31:0] exp_a [4] = '{32'h10, 32'h12, 32'h14, 32'h16};
        ram_hi_mode = 1'b0;
        clear_mon();
        run_pkt(16'h0010, 16'd4, 0, to, fv);
        total++;
        if (to !== 1'b0) begin bad++; $display("FAIL nominal_timeout got=%0d want=0", to); end
        total++;
        if (fv != 1) begin bad++; $display("FAIL nominal_hdr_latency got=%0d want=1", fv); end
        total++;
        if (rd_q.size() != 4) begin
            bad++; $display("FAIL nominal_rd_count got=%0d want=4", rd_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (rd_q[i] !== exp_a[i]) begin
                    bad++; $display("FAIL nominal_rd_addr[%0d] got=%h want=%h", i, rd_q[i], exp_a[i]);
                end
            end
        end
        total++;
        if (got.size() != 6) begin
            bad++; $display("FAIL nominal_words got=%0d want=6", got.size());
        end else begin
            total++;
            if (got[0] !== 64'heb9c_0004_0010_2000) begin
                bad++; $display("FAIL nominal_header got=%h want=eb9c000400102000", got[0]);
            end
            for (int i = 1; i <= 4; i++) begin
                total++;
                if (got[i] !== 64'(32'h10 + 2 * (i - 1))) begin
                    bad++; $display("FAIL nominal_payload[%0d] got=%h want=%h", i, got[i], 64'(32'h10 + 2 * (i - 1)));
                end
            end
            total++;
            if (got[5] !== 64'heb9d_0004_0000_004c) begin
                bad++; $display("FAIL nominal_tail got=%h want=eb9d00040000004c", got[5]);
            end
        end
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL nominal_done got=%0d want=1", done_cnt); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL nominal_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_empty();
        bit to;
        int fv;
        clear_mon();
        run_pkt(16'h1234, 16'd0, 0, to, fv);
        total++;
        if (to !== 1'b0) begin bad++; $display("FAIL empty_timeout got=%0d want=0", to); end
        total++;
        if (rd_q.size() != 0) begin bad++; $display("FAIL empty_reads got=%0d want=0", rd_q.size()); end
        total++;
        if (got.size() != 2) begin
            bad++; $display("FAIL empty_words got=%0d want=2", got.size());
        end else begin
            total++;
            if (got[0] !== 64'heb9c_0000_1234_2000) begin
                bad++; $display("FAIL empty_header got=%h want=eb9c000012342000", got[0]);
            end
            total++;
            if (got[1] !== 64'heb9d_0000_0000_0000) begin
                bad++; $display("FAIL empty_tail got=%h want=eb9d000000000000", got[1]);
            end
        end
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL empty_done got=%0d want=1", done_cnt); end
    endtask

    task automatic test_backpressure();
        bit to;
        int fv;
        ram_hi_mode = 1'b1;
        clear_mon();
        run_pkt(16'h0200, 16'd32, 1, to, fv);
        total++;
        if (to !== 1'b0) begin bad++; $display("FAIL bp_timeout got=%0d want=0", to); end
        total++;
        if (got.size() != 34) begin
            bad++; $display("FAIL bp_words got=%0d want=34", got.size());
        end else begin
            for (int i = 0; i < 34; i++) begin
                total++;
                if (got[i] !== exp_word(16'h0200, 16'd32, i)) begin
                    bad++; $display("FAIL bp_word[%0d] got=%h want=%h", i, got[i], exp_word(16'h0200, 16'd32, i));
                end
            end
        end
        total++;
        if (stab_err != 0) begin bad++; $display("FAIL bp_stability got=%0d want=0", stab_err); end
        total++;
        if (max_sum > 8) begin bad++; $display("FAIL bp_outstanding got=%0d want<=8", max_sum); end
        total++;
        if (rd_q.size() != 32) begin bad++; $display("FAIL bp_reads got=%0d want=32", rd_q.size()); end
    endtask

    task automatic test_collision();
        bit to;
        int fv;
        ram_hi_mode = 1'b1;
        clear_mon();
        run_pkt(16'h0300, 16'd4, 2, to, fv);
        total++;
        if (to !== 1'b0) begin bad++; $display("FAIL coll_timeout got=%0d want=0", to); end
        total++;
        if (drop_cnt != 2) begin bad++; $display("FAIL coll_drops got=%0d want=2", drop_cnt); end
        total++;
        if (got.size() != 6) begin
            bad++; $display("FAIL coll_words got=%0d want=6", got.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (got[i] !== exp_word(16'h0300, 16'd4, i)) begin
                    bad++; $display("FAIL coll_word[%0d] got=%h want=%h", i, got[i], exp_word(16'h0300, 16'd4, i));
                end
            end
        end
        total++;
        if (busy !== 1'b0 || done_cnt != 1) begin
            bad++; $display("FAIL coll_no_queue got busy=%b done=%0d want 0/1", busy, done_cnt);
        end
    endtask

    task automatic test_addr_cross();
        bit to;
        int fv;
        ram_hi_mode = 1'b0;
        clear_mon();
        run_pkt(16'hFFFE, 16'd2, 0, to, fv);
        total++;
        if (to !== 1'b0) begin bad++; $display("FAIL cross_timeout got=%0d want=0", to); end
        total++;
        if (rd_q.size() != 2) begin
            bad++; $display("FAIL cross_reads got=%0d want=2", rd_q.size());
        end else begin
            total++;
            if (rd_q[0] !== 32'h0000_FFFE) begin bad++; $display("FAIL cross_addr0 got=%h want=0000fffe", rd_q[0]); end
            total++;
            if (rd_q[1] !== 32'h0001_0000) begin bad++; $display("FAIL cross_addr1 got=%h want=00010000", rd_q[1]); end
        end
        total++;
        if (got.size() != 4 || got[3] !== 64'heb9d_0002_0000_fffe + 64'h1_0000) begin
            bad++; $display("FAIL cross_tail got=%h want=eb9d00020001fffe", (got.size() == 4) ? got[3] : 64'h0);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int fv;
        int x = 0;
        ram_hi_mode = 1'b1;
        clear_mon();
        cur_len = 8;
        @(posedge clk); #1;
        c2h_en = 1'b1; c2h_addr = 16'h0100; c2h_len = 16'd8; tx_rdy = 1'b1;
        for (int c = 0; c < 60 && x < 4; c++) begin
            @(negedge clk);
            if (tx_vld && tx_rdy) x++;
            @(posedge clk); #1;
            c2h_en = 1'b0;
        end
        total++;
        if (x < 4) begin bad++; $display("FAIL rstmid_progress got=%0d want=4", x); end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({rd_en, tx_vld, busy, done, drop} !== 5'b0) begin
            bad++; $display("FAIL rstmid_flags got=%b want=00000", {rd_en, tx_vld, busy, done, drop});
        end
        total++;
        if (tx_data !== 64'h0 || rd_addr !== 32'h0) begin
            bad++; $display("FAIL rstmid_data got data=%h addr=%h want 0/0", tx_data, rd_addr);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear_mon();
        run_pkt(16'h0040, 16'd1, 0, to, fv);
        total++;
        if (to !== 1'b0) begin bad++; $display("FAIL rstmid_timeout got=%0d want=0", to); end
        total++;
        if (got.size() != 3) begin
            bad++; $display("FAIL rstmid_words got=%0d want=3", got.size());
        end else begin
            total++;
            if (got[1] !== 64'h5A5A_C383_0000_0040) begin
                bad++; $display("FAIL rstmid_payload got=%h want=5a5ac38300000040", got[1]);
            end
            total++;
            if (got[2] !== 64'heb9d_0001_5A5A_C3C3) begin
                bad++; $display("FAIL rstmid_tail got=%h want=eb9d00015a5ac3c3", got[2]);
            end
        end
        total++;
        if (rd_q.size() != 1 || rd_q[0] !== 32'h40) begin
            bad++; $display("FAIL rstmid_reads got n=%0d want one read of 00000040", rd_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_empty();
        test_backpressure();
        test_collision();
        test_addr_cross();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
